// File: rtl/ycbcr_pkg.sv
// Shared widths, emit-phase encodings and helpers for the 4:2:2 -> YCbCr triplet sequencer.
package ycbcr_pkg;

  localparam int BYTE_W    = 8;
  localparam int GRP_BYTES = 4;
  localparam int TRIPLET   = 3;
  localparam int GRP_W     = BYTE_W * GRP_BYTES;

  localparam int INFLIGHT_MIN = 1;
  localparam int INFLIGHT_MAX = 15;

  localparam logic [2:0] PH_Y0   = 3'd0;
  localparam logic [2:0] PH_CB0  = 3'd1;
  localparam logic [2:0] PH_CR0  = 3'd2;
  localparam logic [2:0] PH_Y1   = 3'd3;
  localparam logic [2:0] PH_CB1  = 3'd4;
  localparam logic [2:0] PH_CR1  = 3'd5;
  localparam logic [2:0] PH_LAST = 3'(2 * TRIPLET - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  function automatic int clamp_inflight(input int n);
    if (n < INFLIGHT_MIN) return INFLIGHT_MIN;
    if (n > INFLIGHT_MAX) return INFLIGHT_MAX;
    return n;
  endfunction

  // Stored group layout is {Y1, Cr, Y0, Cb} from MSB to LSB.
  function automatic logic [BYTE_W-1:0] emit_byte(input logic [GRP_W-1:0] grp,
                                                  input logic [2:0] phase);
    case (phase)
      PH_Y0:          emit_byte = grp[1*BYTE_W +: BYTE_W];
      PH_Y1:          emit_byte = grp[3*BYTE_W +: BYTE_W];
      PH_CB0, PH_CB1: emit_byte = grp[0*BYTE_W +: BYTE_W];
      PH_CR0, PH_CR1: emit_byte = grp[2*BYTE_W +: BYTE_W];
      default:        emit_byte = '0;
    endcase
  endfunction

endpackage

// File: rtl/ycbcr422_mac_sequencer_if.sv
// Byte-stream input, triplet output and r/g/b return bus of the MAC sequencer.
interface ycbcr422_mac_sequencer_if;

  logic                           s_valid;
  logic                           s_ready;
  logic                           s_sof;
  logic [ycbcr_pkg::BYTE_W-1:0]   s_data;
  logic                           ycbcr_val;
  logic [ycbcr_pkg::BYTE_W-1:0]   ycbcr_data;
  logic                           r_val;
  logic                           g_val;
  logic                           b_val;
  logic [ycbcr_pkg::BYTE_W-1:0]   r_data;
  logic [ycbcr_pkg::BYTE_W-1:0]   g_data;
  logic [ycbcr_pkg::BYTE_W-1:0]   b_data;
  logic                           pix_val;
  logic [3*ycbcr_pkg::BYTE_W-1:0] pix_rgb;

  modport master (
    output s_valid, s_sof, s_data, r_val, g_val, b_val, r_data, g_data, b_data,
    input  s_ready, ycbcr_val, ycbcr_data, pix_val, pix_rgb
  );

  modport slave (
    input  s_valid, s_sof, s_data, r_val, g_val, b_val, r_data, g_data, b_data,
    output s_ready, ycbcr_val, ycbcr_data, pix_val, pix_rgb
  );

endinterface

// File: rtl/ycbcr422_grp_buf.sv
// Two-entry ping-pong buffer assembling 4:2:2 byte groups; the reader releases whole groups.
module ycbcr422_grp_buf
  import ycbcr_pkg::*;
#(
  parameter int SWAP_CHROMA = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic              wr_sof,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              sof_err,
  input  logic              rd_release,
  output logic              rd_full,
  output logic              nxt_full,
  output logic [GRP_W-1:0]  rd_data,
  output logic [GRP_W-1:0]  nxt_data
);

  logic [GRP_W-1:0] grp_q [2];
  logic [1:0]       full_q;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       idx_q;
  logic             accept;
  logic [1:0]       eff_idx;
  logic [1:0]       pos;

  assign wr_ready = ~full_q[wr_ptr_q];
  assign accept   = wr_valid & wr_ready;
  assign eff_idx  = wr_sof ? 2'd0 : idx_q;
  // In VYUY order the chroma bytes arrive swapped, so positions 0 and 2 trade places.
  assign pos      = ((SWAP_CHROMA != 0) && !eff_idx[0]) ? (eff_idx ^ 2'd2) : eff_idx;
  assign sof_err  = accept & wr_sof & (idx_q != 2'd0);

  assign rd_full  = full_q[rd_ptr_q];
  assign nxt_full = full_q[~rd_ptr_q];
  assign rd_data  = grp_q[rd_ptr_q];
  assign nxt_data = grp_q[~rd_ptr_q];

  // Writes only target a non-full entry and releases only a full one, so they never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      grp_q[0] <= '0;
      grp_q[1] <= '0;
      full_q   <= 2'b00;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      idx_q    <= 2'd0;
    end else begin
      if (accept) begin
        grp_q[wr_ptr_q][pos*BYTE_W +: BYTE_W] <= wr_data;
        if (eff_idx == 2'd3) begin
          full_q[wr_ptr_q] <= 1'b1;
          wr_ptr_q         <= ~wr_ptr_q;
          idx_q            <= 2'd0;
        end else begin
          idx_q <= eff_idx + 2'd1;
        end
      end
      if (rd_release) begin
        full_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q         <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: rtl/ycbcr422_mac_sequencer.sv
// Expands 4:2:2 groups into Y,Cb,Cr triplets for the RGB MACs, throttled by in-flight credits,
// and joins the r/g/b results back into a pixel stream.
module ycbcr422_mac_sequencer
  import ycbcr_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int SWAP_CHROMA  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  ycbcr422_mac_sequencer_if.slave       bus,
  output logic [3:0]                    inflight,
  output logic                          err_align,
  output logic                          err_sof
);

  localparam int         MAX_IF       = clamp_inflight(MAX_INFLIGHT);
  localparam logic [4:0] CREDIT_LIMIT = 5'(MAX_IF);

  logic              s_ready;
  logic              sof_err;
  logic              rd_release;
  logic              rd_full;
  logic              nxt_full;
  logic [GRP_W-1:0]  rd_data;
  logic [GRP_W-1:0]  nxt_data;

  logic [0:0]        state_q, state_d;
  logic [2:0]        phase_q, phase_d;
  logic              val_q, val_d;
  logic [BYTE_W-1:0] data_q, data_d;

  logic [3:0]        inflight_q;
  logic              credit_ok;
  logic              credit_inc;
  logic              ret_all;
  logic              ret_any;
  logic              pix_val_q;
  logic [3*BYTE_W-1:0] pix_rgb_q;
  logic              err_align_q;
  logic              err_sof_q;

  ycbcr422_grp_buf #(.SWAP_CHROMA(SWAP_CHROMA)) u_grp_buf (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (bus.s_valid),
    .wr_sof     (bus.s_sof),
    .wr_data    (bus.s_data),
    .wr_ready   (s_ready),
    .sof_err    (sof_err),
    .rd_release (rd_release),
    .rd_full    (rd_full),
    .nxt_full   (nxt_full),
    .rd_data    (rd_data),
    .nxt_data   (nxt_data)
  );

  // A group is only started when both of its triplets fit under the credit limit.
  assign credit_ok  = ({1'b0, inflight_q} + 5'd2) <= CREDIT_LIMIT;
  assign credit_inc = (state_q == ST_EMIT) && ((phase_q == PH_Y0) || (phase_q == PH_Y1));
  assign ret_all    = bus.r_val & bus.g_val & bus.b_val;
  assign ret_any    = bus.r_val | bus.g_val | bus.b_val;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    val_d      = 1'b0;
    data_d     = '0;
    rd_release = 1'b0;
    if (state_q == ST_IDLE) begin
      if (rd_full && credit_ok) begin
        state_d = ST_EMIT;
        phase_d = PH_Y0;
        val_d   = 1'b1;
        data_d  = emit_byte(rd_data, PH_Y0);
      end
    end else if (phase_q != PH_LAST) begin
      phase_d = phase_q + 3'd1;
      val_d   = 1'b1;
      data_d  = emit_byte(rd_data, phase_q + 3'd1);
    end else begin
      rd_release = 1'b1;
      phase_d    = PH_Y0;
      if (nxt_full && credit_ok) begin
        val_d  = 1'b1;
        data_d = emit_byte(nxt_data, PH_Y0);
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= PH_Y0;
      val_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      val_q   <= val_d;
      data_q  <= data_d;
    end
  end

  // A return with no credit outstanding is treated as a misaligned strobe, not an underflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q  <= 4'd0;
      pix_val_q   <= 1'b0;
      pix_rgb_q   <= '0;
      err_align_q <= 1'b0;
      err_sof_q   <= 1'b0;
    end else begin
      case ({credit_inc, ret_all})
        2'b10:   inflight_q <= inflight_q + 4'd1;
        2'b01:   if (inflight_q != 4'd0) inflight_q <= inflight_q - 4'd1;
        default: ;
      endcase
      pix_val_q <= ret_all;
      if (ret_all) pix_rgb_q <= {bus.r_data, bus.g_data, bus.b_data};
      if ((ret_any && !ret_all) || (ret_all && !credit_inc && (inflight_q == 4'd0)))
        err_align_q <= 1'b1;
      if (sof_err) err_sof_q <= 1'b1;
    end
  end

  assign bus.s_ready    = s_ready;
  assign bus.ycbcr_val  = val_q;
  assign bus.ycbcr_data = data_q;
  assign bus.pix_val    = pix_val_q;
  assign bus.pix_rgb    = pix_rgb_q;
  assign inflight       = inflight_q;
  assign err_align      = err_align_q;
  assign err_sof        = err_sof_q;

endmodule

// File: tb/tb_ycbcr422_mac_sequencer.sv
// Self-checking bench: randomized groups checked against a byte-level 4:2:2 expansion model.
module tb_ycbcr422_mac_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests_run = 0;
  int tests_failed = 0;

  ycbcr422_mac_sequencer_if bus ();
  ycbcr422_mac_sequencer_if bus2 ();
  logic [3:0] inflight, inflight2;
  logic err_align, err_sof, err_align2, err_sof2;

  ycbcr422_mac_sequencer #(.MAX_INFLIGHT(4), .SWAP_CHROMA(0)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .inflight(inflight), .err_align(err_align), .err_sof(err_sof)
  );

  ycbcr422_mac_sequencer #(.MAX_INFLIGHT(4), .SWAP_CHROMA(1)) dut_swap (
    .clk(clk), .rst(rst), .bus(bus2),
    .inflight(inflight2), .err_align(err_align2), .err_sof(err_sof2)
  );

  logic [7:0]  out_q[$];
  int          out_cyc[$];
  logic [23:0] pix_q[$];
  logic [23:0] exp_pix[$];

  always @(negedge clk) begin
    if (bus.ycbcr_val === 1'b1) begin
      out_q.push_back(bus.ycbcr_data);
      out_cyc.push_back(cyc);
    end
    if (bus.pix_val === 1'b1) pix_q.push_back(bus.pix_rgb);
  end

  // Reference: collect accepted bytes into groups, s_sof restarts a group, emit Y0,Cb,Cr,Y1,Cb,Cr.
  logic [7:0] exp_q[$];
  logic [7:0] part[4];
  int         part_n = 0;

  function automatic void model_byte(input logic [7:0] d, input logic sof, input bit swap);
    logic [7:0] cb, cr;
    if (sof) part_n = 0;
    part[part_n] = d;
    part_n++;
    if (part_n == 4) begin
      cb = swap ? part[2] : part[0];
      cr = swap ? part[0] : part[2];
      exp_q.push_back(part[1]); exp_q.push_back(cb); exp_q.push_back(cr);
      exp_q.push_back(part[3]); exp_q.push_back(cb); exp_q.push_back(cr);
      part_n = 0;
    end
  endfunction

  task automatic clear_bench();
    out_q.delete(); out_cyc.delete(); pix_q.delete(); exp_pix.delete(); exp_q.delete();
    part_n = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.s_valid = 0; bus.s_sof = 0; bus.s_data = 0;
    bus.r_val = 0; bus.g_val = 0; bus.b_val = 0;
    bus.r_data = 0; bus.g_data = 0; bus.b_data = 0;
    bus2.s_valid = 0; bus2.s_sof = 0; bus2.s_data = 0;
    bus2.r_val = 0; bus2.g_val = 0; bus2.b_val = 0;
    bus2.r_data = 0; bus2.g_data = 0; bus2.b_data = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_bench();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic sof, output int acc);
    acc = -1;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_sof   = sof;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.s_ready === 1'b1) begin
        @(posedge clk);
        #1;
        acc = cyc;
        model_byte(d, sof, 1'b0);
        break;
      end
    end
    if (acc < 0) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL send_byte_timeout: s_ready=%b, required 1 within 300 cycles", bus.s_ready);
    end
    bus.s_sof = 1'b0;
  endtask

  task automatic return_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                           input logic [2:0] m);
    @(posedge clk);
    #1;
    bus.r_val = m[2]; bus.g_val = m[1]; bus.b_val = m[0];
    bus.r_data = r; bus.g_data = g; bus.b_data = b;
    @(posedge clk);
    #1;
    bus.r_val = 0; bus.g_val = 0; bus.b_val = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests_run++; if (bus.s_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_s_ready: got %b want 1", bus.s_ready); end
    tests_run++; if (bus.ycbcr_val !== 1'b0 || bus.ycbcr_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_ycbcr: got val=%b data=%h want 0/00", bus.ycbcr_val, bus.ycbcr_data); end
    tests_run++; if (inflight !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_inflight: got %0d want 0", inflight); end
    tests_run++; if (bus.pix_val !== 1'b0 || bus.pix_rgb !== 24'h0) begin tests_failed++; $display("[TB] FAIL reset_pix: got val=%b rgb=%h want 0/000000", bus.pix_val, bus.pix_rgb); end
    tests_run++; if (err_align !== 1'b0 || err_sof !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_errs: got align=%b sof=%b want 0/0", err_align, err_sof); end
  endtask

  task automatic test_single_group();
    logic [7:0] want [6];
    int a, acc4;
    want = '{8'h10, 8'h80, 8'h90, 8'h20, 8'h80, 8'h90};
    do_reset();
    send_byte(8'h80, 1'b1, a);
    send_byte(8'h10, 1'b0, a);
    send_byte(8'h90, 1'b0, a);
    send_byte(8'h20, 1'b0, acc4);
    bus.s_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    tests_run++; if (out_q.size() != 6) begin tests_failed++; $display("[TB] FAIL single_count: got %0d bytes want 6", out_q.size()); end
    for (int i = 0; i < 6 && i < out_q.size(); i++) begin
      tests_run++;
      if (out_q[i] !== want[i] || out_cyc[i] != acc4 + 1 + i) begin
        tests_failed++;
        $display("[TB] FAIL single_byte%0d: got %h at cycle %0d want %h at cycle %0d", i, out_q[i], out_cyc[i], want[i], acc4 + 1 + i);
      end
    end
    tests_run++; if (inflight !== 4'd2) begin tests_failed++; $display("[TB] FAIL single_inflight: got %0d want 2", inflight); end
  endtask

  task automatic test_back_to_back();
    int bad;
    do_reset();
    fork
      begin : drive
        int a;
        for (int gi = 0; gi < 8; gi++)
          for (int k = 0; k < 4; k++)
            send_byte(8'($urandom_range(0, 255)), k == 0, a);
        bus.s_valid = 1'b0;
      end
      begin : returns
        logic [7:0] r, g, b;
        for (int rnd = 0; rnd < 4; rnd++) begin
          repeat (40) @(posedge clk);
          if (rnd == 0) begin
            @(negedge clk);
            tests_run++; if (out_q.size() != 12) begin tests_failed++; $display("[TB] FAIL b2b_stall_count: got %0d bytes want 12", out_q.size()); end
            tests_run++; if (bus.s_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_s_ready: got %b want 0", bus.s_ready); end
            tests_run++; if (inflight !== 4'd4) begin tests_failed++; $display("[TB] FAIL b2b_inflight: got %0d want 4", inflight); end
            tests_run++; if (out_cyc.size() != 12 || out_cyc[11] - out_cyc[0] != 11) begin tests_failed++; $display("[TB] FAIL b2b_gapless: got %0d bytes spanning %0d cycles want 12 over 12", out_cyc.size(), out_cyc.size() > 0 ? out_cyc[out_cyc.size()-1] - out_cyc[0] + 1 : 0); end
          end
          for (int p = 0; p < 4; p++) begin
            r = 8'($urandom_range(0, 255)); g = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
            exp_pix.push_back({r, g, b});
            return_px(r, g, b, 3'b111);
          end
        end
      end
    join
    repeat (20) @(posedge clk);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) if (out_q[i] !== exp_q[i]) bad++;
    tests_run++; if (out_q.size() != 48 || exp_q.size() != 48 || bad != 0) begin tests_failed++; $display("[TB] FAIL b2b_stream: got %0d bytes (%0d wrong) want 48 model bytes (%0d)", out_q.size(), bad, exp_q.size()); end
    bad = 0;
    for (int i = 0; i < exp_pix.size() && i < pix_q.size(); i++) if (pix_q[i] !== exp_pix[i]) bad++;
    tests_run++; if (pix_q.size() != 16 || bad != 0) begin tests_failed++; $display("[TB] FAIL b2b_pixels: got %0d pixels (%0d wrong) want 16", pix_q.size(), bad); end
    tests_run++; if (inflight !== 4'd0 || err_align !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_final: got inflight=%0d err_align=%b want 0/0", inflight, err_align); end
  endtask

  task automatic test_return_join();
    logic [7:0] r, g, b;
    int a;
    do_reset();
    for (int k = 0; k < 4; k++) send_byte(8'($urandom_range(0, 255)), k == 0, a);
    bus.s_valid = 1'b0;
    repeat (10) @(posedge clk);
    return_px(8'h55, 8'h00, 8'h00, 3'b100);
    @(negedge clk);
    tests_run++; if (bus.pix_val !== 1'b0 || err_align !== 1'b1 || inflight !== 4'd2) begin tests_failed++; $display("[TB] FAIL join_partial: got pix_val=%b err_align=%b inflight=%0d want 0/1/2", bus.pix_val, err_align, inflight); end
    return_px(8'h11, 8'h22, 8'h33, 3'b111);
    @(negedge clk);
    tests_run++; if (bus.pix_val !== 1'b1 || bus.pix_rgb !== 24'h112233 || inflight !== 4'd1) begin tests_failed++; $display("[TB] FAIL join_fixed: got val=%b rgb=%h inflight=%0d want 1/112233/1", bus.pix_val, bus.pix_rgb, inflight); end
    @(negedge clk);
    tests_run++; if (bus.pix_val !== 1'b0) begin tests_failed++; $display("[TB] FAIL join_one_cycle: got pix_val=%b want 0", bus.pix_val); end
    r = 8'($urandom_range(0, 255)); g = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
    return_px(r, g, b, 3'b111);
    @(negedge clk);
    tests_run++; if (bus.pix_val !== 1'b1 || bus.pix_rgb !== {r, g, b} || inflight !== 4'd0) begin tests_failed++; $display("[TB] FAIL join_random: got val=%b rgb=%h inflight=%0d want 1/%h/0", bus.pix_val, bus.pix_rgb, inflight, {r, g, b}); end
    do_reset();
    return_px(r, g, b, 3'b111);
    @(negedge clk);
    tests_run++; if (inflight !== 4'd0 || err_align !== 1'b1) begin tests_failed++; $display("[TB] FAIL join_underflow: got inflight=%0d err_align=%b want 0/1", inflight, err_align); end
  endtask

  task automatic test_sof_restart();
    logic [7:0] new_cb;
    int a, bad;
    do_reset();
    send_byte(8'($urandom_range(0, 255)), 1'b1, a);
    send_byte(8'($urandom_range(0, 255)), 1'b0, a);
    bus.s_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (err_sof !== 1'b0) begin tests_failed++; $display("[TB] FAIL sof_early: got err_sof=%b want 0", err_sof); end
    new_cb = 8'($urandom_range(0, 255));
    send_byte(new_cb, 1'b1, a);
    for (int k = 0; k < 3; k++) send_byte(8'($urandom_range(0, 255)), 1'b0, a);
    bus.s_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    tests_run++; if (err_sof !== 1'b1) begin tests_failed++; $display("[TB] FAIL sof_flag: got err_sof=%b want 1", err_sof); end
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) if (out_q[i] !== exp_q[i]) bad++;
    tests_run++; if (out_q.size() != 6 || bad != 0 || out_q[1] !== new_cb) begin tests_failed++; $display("[TB] FAIL sof_stream: got %0d bytes (%0d wrong) Cb=%h want 6 bytes Cb=%h", out_q.size(), bad, out_q.size() > 1 ? out_q[1] : 8'h00, new_cb); end
  endtask

  task automatic test_reset_mid_emit();
    int a, seen, bad;
    do_reset();
    return_px(8'h00, 8'h01, 8'h00, 3'b010);
    send_byte(8'($urandom_range(0, 255)), 1'b1, a);
    send_byte(8'($urandom_range(0, 255)), 1'b0, a);
    send_byte(8'($urandom_range(0, 255)), 1'b1, a);
    for (int k = 0; k < 3; k++) send_byte(8'($urandom_range(0, 255)), 1'b0, a);
    bus.s_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 50 && seen < 4; i++) begin
      @(negedge clk);
      if (bus.ycbcr_val === 1'b1) seen++;
    end
    tests_run++; if (seen != 4 || err_sof !== 1'b1 || err_align !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_setup: got %0d bytes err_sof=%b err_align=%b want 4/1/1", seen, err_sof, err_align); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++; if (bus.ycbcr_val !== 1'b0 || inflight !== 4'd0 || bus.s_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_outputs: got val=%b inflight=%0d s_ready=%b want 0/0/1", bus.ycbcr_val, inflight, bus.s_ready); end
    tests_run++; if (err_sof !== 1'b0 || err_align !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_errs: got err_sof=%b err_align=%b want 0/0", err_sof, err_align); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_bench();
    for (int k = 0; k < 4; k++) send_byte(8'($urandom_range(0, 255)), k == 0, a);
    bus.s_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) if (out_q[i] !== exp_q[i]) bad++;
    tests_run++; if (out_q.size() != 6 || bad != 0 || inflight !== 4'd2) begin tests_failed++; $display("[TB] FAIL rstmid_after: got %0d bytes (%0d wrong) inflight=%0d want 6/0/2", out_q.size(), bad, inflight); end
  endtask

  task automatic test_swap_chroma();
    logic [7:0] fixed_in [4];
    logic [7:0] want [6];
    logic [7:0] grp [4];
    logic [7:0] got [$];
    int bad;
    fixed_in = '{8'h90, 8'h10, 8'h80, 8'h20};
    want     = '{8'h10, 8'h80, 8'h90, 8'h20, 8'h80, 8'h90};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus2.s_valid = 1'b1; bus2.s_data = fixed_in[k]; bus2.s_sof = (k == 0);
      @(posedge clk);
      #1;
    end
    bus2.s_valid = 1'b0; bus2.s_sof = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus2.ycbcr_val === 1'b1) got.push_back(bus2.ycbcr_data);
    end
    bad = 0;
    for (int i = 0; i < 6 && i < got.size(); i++) if (got[i] !== want[i]) bad++;
    tests_run++; if (got.size() != 6 || bad != 0) begin tests_failed++; $display("[TB] FAIL swap_fixed: got %0d bytes (%0d wrong) want 6 matching 10,80,90,20,80,90", got.size(), bad); end
    got.delete();
    exp_q.delete();
    part_n = 0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      grp[k] = 8'($urandom_range(0, 255));
      model_byte(grp[k], k == 0, 1'b1);
      bus2.s_valid = 1'b1; bus2.s_data = grp[k]; bus2.s_sof = (k == 0);
      @(negedge clk);
      if (bus2.s_ready !== 1'b1) begin tests_run++; tests_failed++; $display("[TB] FAIL swap_ready: got s_ready=%b want 1", bus2.s_ready); end
      @(posedge clk);
      #1;
    end
    bus2.s_valid = 1'b0; bus2.s_sof = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus2.ycbcr_val === 1'b1) got.push_back(bus2.ycbcr_data);
    end
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) if (got[i] !== exp_q[i]) bad++;
    tests_run++; if (got.size() != 6 || bad != 0) begin tests_failed++; $display("[TB] FAIL swap_random: got %0d bytes (%0d wrong) want 6 model bytes", got.size(), bad); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single_group();
    test_back_to_back();
    test_return_join();
    test_sof_restart();
    test_reset_mid_emit();
    test_swap_chroma();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
